// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: opcode encodings, NOP word, fetch states
// and the decoded-instruction layout.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ADDI x0,x0,0
    localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetch_state_e;

    // Field order matches the bit layout of an R-type word, MSB first
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } dec_insn_t;

    function automatic logic is_rv32i_opcode(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate generator: all five sign-extended immediate
// formats from one instruction word, independent of opcode.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] insn,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    // Opcode bits never contribute to an immediate
    logic [6:0] unused_opcode;
    assign unused_opcode = insn[6:0];

    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u = {insn[31:12], 12'b0};
    assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch + field decode with valid/ready output, fetch timeout and
// misaligned-PC handling. Optional opcode legality check: ILLEGAL_INSN_CHECK_EN.
module fetch_decode
    import rv32_pkg::*;
#(
    parameter int unsigned     TIMEOUT_CYCLES = 16,
    parameter logic [XLEN-1:0] NOP_INSN       = RV32_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_rvalid,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm_i_type,
    output logic [XLEN-1:0] imm_s_type,
    output logic [XLEN-1:0] imm_b_type,
    output logic [XLEN-1:0] imm_u_type,
    output logic [XLEN-1:0] imm_j_type,
    output logic            fetch_err,
    output logic            misaligned,
    output logic            illegal
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] insn_q, insn_d;
    logic [XLEN-1:0] addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            req_d, valid_d, err_d, mis_d, ill_d;

    logic handshake_c, launch_c, aligned_c, timeout_c, bad_opcode_c;

    assign handshake_c = dec_valid & dec_ready;
    assign aligned_c   = (pc_in[1:0] == 2'b00);
    assign timeout_c   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // A new PC is taken from IDLE, or straight out of HOLD as the current word leaves
    assign launch_c    = pc_valid & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & handshake_c));

`ifdef ILLEGAL_INSN_CHECK_EN
    assign bad_opcode_c = ~is_rv32i_opcode(imem_rdata[6:0]);
`else
    assign bad_opcode_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch_c) state_d = aligned_c ? ST_REQ : ST_HOLD;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (imem_rvalid || timeout_c) state_d = ST_HOLD;
            ST_HOLD: begin
                if (launch_c) begin
                    state_d = aligned_c ? ST_REQ : ST_HOLD;
                end else if (handshake_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values, registered below
    always_comb begin
        insn_d  = insn_q;
        addr_d  = imem_addr;
        cnt_d   = cnt_q;
        err_d   = fetch_err;
        mis_d   = misaligned;
        ill_d   = illegal;
        req_d   = (state_d == ST_REQ);
        valid_d = (state_d == ST_HOLD);

        if (launch_c) begin
            if (aligned_c) begin
                addr_d = pc_in;
            end else begin
                insn_d = NOP_INSN;
                err_d  = 1'b0;
                mis_d  = 1'b1;
                ill_d  = 1'b0;
            end
        end

        if (state_q == ST_REQ) begin
            cnt_d = '0;
        end

        // rvalid takes priority over a timeout landing in the same cycle
        if (state_q == ST_WAIT) begin
            if (imem_rvalid) begin
                insn_d = bad_opcode_c ? NOP_INSN : imem_rdata;
                err_d  = 1'b0;
                mis_d  = 1'b0;
                ill_d  = bad_opcode_c;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout_c) begin
                    insn_d = NOP_INSN;
                    err_d  = 1'b1;
                    mis_d  = 1'b0;
                    ill_d  = 1'b0;
                end
            end
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            insn_q     <= NOP_INSN;
            imem_addr  <= '0;
            cnt_q      <= '0;
            imem_req   <= 1'b0;
            dec_valid  <= 1'b0;
            fetch_err  <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            insn_q     <= insn_d;
            imem_addr  <= addr_d;
            cnt_q      <= cnt_d;
            imem_req   <= req_d;
            dec_valid  <= valid_d;
            fetch_err  <= err_d;
            misaligned <= mis_d;
            illegal    <= ill_d;
        end
    end

    dec_insn_t fields_c;
    assign fields_c = dec_insn_t'(insn_q);
    assign opcode   = fields_c.opcode;
    assign rd       = fields_c.rd;
    assign funct3   = fields_c.funct3;
    assign rs1      = fields_c.rs1;
    assign rs2      = fields_c.rs2;
    assign funct7   = fields_c.funct7;

    rv32_imm_gen u_imm_gen (
        .insn  (insn_q),
        .imm_i (imm_i_type),
        .imm_s (imm_s_type),
        .imm_b (imm_b_type),
        .imm_u (imm_u_type),
        .imm_j (imm_j_type)
    );

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed cases plus randomized fetches
// against an arithmetic reference of the decode and the fetch outcome.
module tb_fetch_decode;

    localparam int unsigned TO  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        dec_valid;
    logic        dec_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm_i_type, imm_s_type, imm_b_type, imm_u_type, imm_j_type;
    logic        fetch_err, misaligned, illegal;

    fetch_decode #(.TIMEOUT_CYCLES(TO), .NOP_INSN(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_rvalid(imem_rvalid), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm_i_type(imm_i_type), .imm_s_type(imm_s_type),
        .imm_b_type(imm_b_type), .imm_u_type(imm_u_type), .imm_j_type(imm_j_type),
        .fetch_err(fetch_err), .misaligned(misaligned), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] cur_w;
    bit          cur_e, cur_m, cur_il;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Immediates rebuilt from bit weights with plain integer arithmetic
    function automatic logic [31:0] ref_imm_i(input logic [31:0] w);
        int v;
        v = int'((w >> 20) & 32'h7FF) - (w[31] ? 2048 : 0);
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_imm_s(input logic [31:0] w);
        int v;
        v = int'((w >> 25) & 32'h3F) * 32 + int'((w >> 7) & 32'h1F) - (w[31] ? 2048 : 0);
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_imm_b(input logic [31:0] w);
        int v;
        v = int'((w >> 8) & 32'hF) * 2 + int'((w >> 25) & 32'h3F) * 32
          + int'((w >> 7) & 32'h1) * 2048 - (w[31] ? 4096 : 0);
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_imm_j(input logic [31:0] w);
        int v;
        v = int'((w >> 21) & 32'h3FF) * 2 + int'((w >> 20) & 32'h1) * 2048
          + int'((w >> 12) & 32'hFF) * 4096 - (w[31] ? 1048576 : 0);
        return 32'(v);
    endfunction

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    endfunction

    // What the execute stage should see for a fetch of word at pc answered after lat cycles
    task automatic predict(input logic [31:0] pc, input logic [31:0] word, input int lat,
                           output logic [31:0] w, output bit e, output bit m, output bit il);
        w = word; e = 0; m = 0; il = 0;
        if (pc % 4 != 0) begin
            w = NOP; m = 1;
        end else if (lat > int'(TO)) begin
            w = NOP; e = 1;
        end else begin
`ifdef ILLEGAL_INSN_CHECK_EN
            if (!legal_op(word[6:0])) begin
                w = NOP; il = 1;
            end
`endif
        end
    endtask

    task automatic check_out(input string tag);
        check({tag, ".opcode"}, 32'(opcode), cur_w % 128);
        check({tag, ".rd"},     32'(rd),     (cur_w / 128) % 32);
        check({tag, ".funct3"}, 32'(funct3), (cur_w / 4096) % 8);
        check({tag, ".rs1"},    32'(rs1),    (cur_w / 32768) % 32);
        check({tag, ".rs2"},    32'(rs2),    (cur_w / 1048576) % 32);
        check({tag, ".funct7"}, 32'(funct7), cur_w / 33554432);
        check({tag, ".imm_i"},  imm_i_type,  ref_imm_i(cur_w));
        check({tag, ".imm_s"},  imm_s_type,  ref_imm_s(cur_w));
        check({tag, ".imm_b"},  imm_b_type,  ref_imm_b(cur_w));
        check({tag, ".imm_u"},  imm_u_type,  cur_w & 32'hFFFF_F000);
        check({tag, ".imm_j"},  imm_j_type,  ref_imm_j(cur_w));
        check({tag, ".fetch_err"},  32'(fetch_err),  32'(cur_e));
        check({tag, ".misaligned"}, 32'(misaligned), 32'(cur_m));
        check({tag, ".illegal"},    32'(illegal),    32'(cur_il));
    endtask

    // Called on a negedge where the DUT is IDLE, or HOLD with dec_ready already high.
    // Memory answers lat cycles into WAIT; lat > TO means it answers too late or never.
    task automatic launch(input logic [31:0] pc, input logic [31:0] word, input int lat,
                          input string tag);
        bit got;
        predict(pc, word, lat, cur_w, cur_e, cur_m, cur_il);
        pc_in = pc;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        dec_ready = 1'b0;
        pc_in = $urandom;
        check({tag, ".req"}, 32'(imem_req), 32'(!cur_m));
        if (!cur_m) check({tag, ".addr"}, imem_addr, pc);
        // rvalid noise during REQ must be ignored
        imem_rvalid = (!cur_m && lat >= 2) ? 1'($urandom) : 1'b0;
        imem_rdata  = $urandom;
        got = dec_valid;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk);
            if (dec_valid) begin
                got = 1;
            end else begin
                check({tag, ".req_idle"}, 32'(imem_req), 32'd0);
                imem_rvalid = (c == lat);
                imem_rdata  = (c == lat) ? word : $urandom;
            end
        end
        imem_rvalid = 1'b0;
        check({tag, ".valid_seen"}, 32'(got), 32'd1);
        check({tag, ".req_hold"}, 32'(imem_req), 32'd0);
        check_out(tag);
    endtask

    // Backpressure: outputs frozen, memory noise ignored, no new request
    task automatic stall(input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            imem_rvalid = 1'($urandom);
            imem_rdata  = $urandom;
            @(negedge clk);
            check({tag, ".stall_valid"}, 32'(dec_valid), 32'd1);
            check({tag, ".stall_req"},   32'(imem_req),  32'd0);
            check_out({tag, ".stall"});
        end
        imem_rvalid = 1'b0;
    endtask

    task automatic release_idle(input string tag);
        dec_ready = 1'b1;
        pc_valid  = 1'b0;
        @(negedge clk);
        dec_ready = 1'b0;
        check({tag, ".idle_valid"}, 32'(dec_valid), 32'd0);
        check({tag, ".idle_req"},   32'(imem_req),  32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid"},  32'(dec_valid), 32'd0);
        check({tag, ".req"},    32'(imem_req),  32'd0);
        check({tag, ".opcode"}, 32'(opcode),    32'h13);
        check({tag, ".rd"},     32'(rd),        32'd0);
        check({tag, ".imm_i"},  imm_i_type,     32'd0);
        check({tag, ".err"},    32'(fetch_err), 32'd0);
        check({tag, ".mis"},    32'(misaligned), 32'd0);
        check({tag, ".ill"},    32'(illegal),   32'd0);
    endtask

    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    initial begin
        bit          in_hold;
        logic [31:0] pc, w;
        int          lat;

        rst_n = 1'b0; pc_in = '0; pc_valid = 1'b0;
        imem_rdata = '0; imem_rvalid = 1'b0; dec_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        check("reset.addr", imem_addr, 32'd0);
        rst_n = 1'b1;

        launch(32'h0, 32'h0050_0093, 1, "addi");
        check("addi.const_opcode", 32'(opcode), 32'h13);
        check("addi.const_rd", 32'(rd), 32'd1);
        check("addi.const_imm_i", imm_i_type, 32'd5);
        stall(5, "bp");
        dec_ready = 1'b1;
        launch(32'h4, 32'h0020_A423, 1, "sw");
        check("sw.const_imm_s", imm_s_type, 32'd8);
        check("sw.const_rs2", 32'(rs2), 32'd2);
        dec_ready = 1'b1;
        launch(32'h8, 32'hFE00_0EE3, 3, "beq");
        check("beq.const_imm_b", imm_b_type, 32'hFFFF_FFFC);
        dec_ready = 1'b1;
        launch(32'hC, 32'h1234_50B7, 2, "lui");
        check("lui.const_imm_u", imm_u_type, 32'h1234_5000);
        release_idle("lui");

        launch(32'h10, 32'h0000_0033, 99, "tmo");
        check("tmo.const_err", 32'(fetch_err), 32'd1);
        check("tmo.const_opcode", 32'(opcode), 32'h13);
        stall(3, "tmo");
        release_idle("tmo");
        launch(32'h14, 32'h00A0_0513, 16, "edge16");
        release_idle("edge16");
        launch(32'h18, 32'h00A0_0513, 17, "edge17");
        stall(2, "edge17");
        release_idle("edge17");

        launch(32'h6, 32'h00A0_0513, 1, "mis");
        check("mis.const_mis", 32'(misaligned), 32'd1);
        dec_ready = 1'b1;
        launch(32'h7, 32'h00A0_0513, 1, "mis2");
        dec_ready = 1'b1;
        launch(32'h20, 32'h0000_0533, 2, "after_mis");
        release_idle("after_mis");

        // Reset while WAIT, with a late rvalid afterwards
        pc_in = 32'h40; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_wait.valid", 32'(dec_valid), 32'd0);
        check("rst_wait.req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
        @(negedge clk);
        imem_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_wait.late_valid", 32'(dec_valid), 32'd0);
            check("rst_wait.late_req", 32'(imem_req), 32'd0);
        end
        launch(32'h44, 32'h0030_8113, 2, "post_rst");
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("rst_hold");
        rst_n = 1'b1;

        in_hold = 0;
        for (int t = 0; t < 80; t++) begin
            pc = 32'($urandom_range(0, 4095)) * 4;
            if ($urandom_range(0, 7) == 0) pc = pc + 32'($urandom_range(1, 3));
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 8)];
            lat = ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(1, 18));
            if (in_hold) begin
                if ($urandom_range(0, 2) == 0) release_idle("rnd");
                else dec_ready = 1'b1;
            end
            launch(pc, w, lat, "rnd");
            in_hold = 1;
            stall($urandom_range(0, 3), "rnd");
        end
        release_idle("rnd_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
